// File: rtl/ddr3_arb_pkg.sv
// Shared constants, command encodings and FSM state type for the DDR3 port arbiter.
// Used by ddr3_port_arbiter and ddr3_arb_tag_fifo.
package ddr3_arb_pkg;

    localparam int DDR3_ADDR_W = 27;
    localparam int DDR3_DATA_W = 128;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_ARB   = 3'b010,
        ST_ISSUE = 3'b100
    } arb_state_t;

    // Index width for a vector of n entries, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// Port-tag FIFO remembering which requester issued each outstanding read.
// Head entry is visible combinationally so a returning beat can be routed in the same cycle.
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = idxWidth(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;

    // DEPTH is a power of two, so the pointers wrap naturally on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/ddr3_port_arbiter.sv
// Round-robin arbiter sharing one Gowin DDR3 native interface between PORTS requesters.
// Define DDR3_ARB_WR_PRIORITY_EN to let eligible writes win over eligible reads.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int PORTS     = 2,
    parameter int TAG_DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           init_calib_complete,
    input  logic [PORTS-1:0]               p_req,
    input  logic [PORTS-1:0]               p_rd,
    input  logic [PORTS*DDR3_ADDR_W-1:0]   p_addr,
    input  logic [PORTS*DDR3_DATA_W-1:0]   p_wdata,
    output logic [PORTS-1:0]               p_ack,
    output logic [PORTS-1:0]               p_rd_valid,
    output logic [DDR3_DATA_W-1:0]         p_rd_data,
    input  logic                           cmd_ready,
    output logic [2:0]                     cmd,
    output logic                           cmd_en,
    output logic [DDR3_ADDR_W-1:0]         addr,
    input  logic                           wr_data_rdy,
    output logic [DDR3_DATA_W-1:0]         wr_data,
    output logic                           wr_data_en,
    output logic                           wr_data_end,
    input  logic [DDR3_DATA_W-1:0]         rd_data,
    input  logic                           rd_data_valid,
    output logic [$clog2(TAG_DEPTH):0]     rd_outstanding,
    output logic                           tag_err
);

    localparam int IDX_W = idxWidth(PORTS);

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    logic [IDX_W-1:0]       r_gnt_idx;
    logic                   r_gnt_rd;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic                   r_tag_err;

    logic [DDR3_ADDR_W-1:0] w_port_addr  [PORTS];
    logic [DDR3_DATA_W-1:0] w_port_wdata [PORTS];
    logic [PORTS-1:0]       w_wr_elig;
    logic [PORTS-1:0]       w_rd_elig;
    logic [IDX_W:0]         w_pick_res;
    logic                   w_found;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_handshake;
    logic                   w_push;
    logic                   w_pop;
    logic [IDX_W-1:0]       w_tag;
    logic                   w_tag_full;
    logic                   w_tag_empty;

    for (genvar g = 0; g < PORTS; g++) begin : g_port
        assign w_port_addr[g]  = p_addr[g*DDR3_ADDR_W +: DDR3_ADDR_W];
        assign w_port_wdata[g] = p_wdata[g*DDR3_DATA_W +: DDR3_DATA_W];
    end

    // Returns {found, index} of the first set bit of mask scanning upward from ptr.
    function automatic logic [IDX_W:0] rrPick(input logic [PORTS-1:0] mask,
                                              input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] cand;
        logic [IDX_W:0]   res;
        res = '0;
        for (int k = 0; k < PORTS; k++) begin
            cand = IDX_W'((int'(ptr) + k) % PORTS);
            if (!res[IDX_W] && mask[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    assign w_wr_elig = p_req & ~p_rd;
    assign w_rd_elig = p_req & p_rd & {PORTS{~w_tag_full}};

`ifdef DDR3_ARB_WR_PRIORITY_EN
    assign w_pick_res = (|w_wr_elig) ? rrPick(w_wr_elig, r_rr_ptr)
                                     : rrPick(w_rd_elig, r_rr_ptr);
`else
    assign w_pick_res = rrPick(w_wr_elig | w_rd_elig, r_rr_ptr);
`endif

    assign w_found = w_pick_res[IDX_W];
    assign w_pick  = w_pick_res[IDX_W-1:0];

    always_comb begin
        w_next_state = r_state;
        cmd_en       = 1'b0;
        cmd          = '0;
        addr         = '0;
        wr_data      = '0;
        wr_data_en   = 1'b0;
        wr_data_end  = 1'b0;
        p_ack        = '0;
        w_handshake  = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (init_calib_complete) w_next_state = ST_ARB;
            end
            ST_ARB: begin
                if (w_found) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                cmd_en = 1'b1;
                addr   = w_port_addr[r_gnt_idx];
                cmd    = r_gnt_rd ? CMD_RD : CMD_WR;
                if (!r_gnt_rd) begin
                    wr_data_en  = 1'b1;
                    wr_data_end = 1'b1;
                    wr_data     = w_port_wdata[r_gnt_idx];
                end
                w_handshake = cmd_ready & (r_gnt_rd | wr_data_rdy);
                if (w_handshake) begin
                    p_ack[r_gnt_idx] = 1'b1;
                    w_push           = r_gnt_rd;
                    w_next_state     = ST_ARB;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Direction is latched at grant so a requester misbehaving mid-issue cannot change the command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt_idx <= '0;
            r_gnt_rd  <= 1'b0;
            r_rr_ptr  <= '0;
            r_tag_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_ARB && w_found) begin
                r_gnt_idx <= w_pick;
                r_gnt_rd  <= p_rd[w_pick];
            end
            if (w_handshake) begin
                r_rr_ptr <= (r_gnt_idx == IDX_W'(PORTS - 1)) ? '0 : r_gnt_idx + 1'b1;
            end
            if (rd_data_valid && w_tag_empty) r_tag_err <= 1'b1;
        end
    end

    assign w_pop   = rd_data_valid & ~w_tag_empty;
    assign tag_err = r_tag_err;

    always_comb begin
        p_rd_valid = '0;
        p_rd_data  = '0;
        if (w_pop) begin
            p_rd_valid[w_tag] = 1'b1;
            p_rd_data         = rd_data;
        end
    end

    ddr3_arb_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_gnt_idx),
        .i_pop       (w_pop),
        .o_pop_data  (w_tag),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_count     (rd_outstanding)
    );

endmodule

// File: doc/ddr3_port_arbiter.md
# ddr3_port_arbiter

Shares the single Gowin DDR3 native command/write/read interface between `PORTS` independent requesters in the `app_clk` domain. Requests are granted round-robin, with optional write priority. Each accepted request becomes exactly one BL8 command: one 128-bit beat at 1:4 clock ratio. Read data returns in order from the memory IP and is routed back to the issuing port through an internal port-tag FIFO. The block sits between several FIFO-style DDR3 clients (stream buffers, frame readers) and `DDR3_Memory_Interface_Top`.

## Interface
Parameters:
- `PORTS`, 2: number of requesters, 2..4.
- `TAG_DEPTH`, 8: maximum outstanding reads; power of two, 2..16.

Ports:
- `clk` in 1: `app_clk` from the DDR3 IP (`clk_out`).
- `rst_n` in 1: asynchronous, active-low reset.
- `init_calib_complete` in 1: DDR3 IP calibration done.
- `p_req` in PORTS: per-port request; held until `p_ack`.
- `p_rd` in PORTS: 1 = read, 0 = write; stable while `p_req`.
- `p_addr` in PORTS*27: packed DQ addresses, 8-aligned; port i at [27i+26:27i].
- `p_wdata` in PORTS*128: packed write beats.
- `p_ack` out PORTS: one-cycle pulse when the port's command handshakes.
- `p_rd_valid` out PORTS: one-hot read-return strobe.
- `p_rd_data` out 128: read data, shared by all ports; qualified by `p_rd_valid`.
- `cmd_ready` in 1; `cmd` out 3; `cmd_en` out 1; `addr` out 27: IP command channel.
- `wr_data_rdy` in 1; `wr_data` out 128; `wr_data_en` out 1; `wr_data_end` out 1: IP write channel.
- `rd_data` in 128; `rd_data_valid` in 1: IP read channel.
- `rd_outstanding` out $clog2(TAG_DEPTH)+1: reads issued but not yet returned.
- `tag_err` out 1: sticky; set when read data arrives with no tag.

## Operation
- FSM states:
  - IDLE: wait for `init_calib_complete`, then go to ARB.
  - ARB: choose a port, latch its index into `gnt_idx`, go to ISSUE. Stay in ARB if no port is eligible.
  - ISSUE: drive the command until handshake, then go to ARB.
- Eligibility:
  - Write port: `p_req & !p_rd`.
  - Read port: `p_req & p_rd & !tag_full`.
- Round-robin:
  - Search starts at `rr_ptr`.
  - After each `p_ack`, `rr_ptr` becomes `gnt_idx+1`, wrapping from PORTS-1 to 0.
- ISSUE outputs:
  - `cmd_en=1`, `addr=p_addr[gnt_idx]`, `cmd=3'b001` for a read, `3'b000` for a write.
  - For a write, also `wr_data_en = wr_data_end = 1` and `wr_data=p_wdata[gnt_idx]`, in the same cycle as `cmd_en`.
- Handshake:
  - Read: `cmd_ready`.
  - Write: `cmd_ready & wr_data_rdy`.
  - On handshake: `p_ack[gnt_idx]=1`. A read also pushes `gnt_idx` into the tag FIFO.
- Read return: each `rd_data_valid` pops the tag FIFO and drives `p_rd_valid[tag]=1`, with `p_rd_data=rd_data` passed through combinationally.
- `rd_outstanding` = tag FIFO occupancy. Push and pop in the same cycle leave it unchanged.
- Outside ISSUE: `cmd_en`, `wr_data_en` and `wr_data_end` are 0; `cmd`, `addr` and `wr_data` are 0.
- Boundary conditions:
  - Tag FIFO full: read ports are ineligible; write ports still proceed.
  - `rd_data_valid` with the FIFO empty: no `p_rd_valid`, set `tag_err`; occupancy stays 0.
  - `p_req` dropped during ISSUE: protocol violation; the command still completes.
  - `init_calib_complete` falling: no effect once past IDLE.
  - Reset mid-operation: all state clears and outstanding tags are discarded.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; `rr_ptr=0`; tag FIFO empty.
- Request to command: `p_req` sampled in ARB at cycle N; `cmd_en` asserts at N+1.
- `p_ack` is combinational in the handshake cycle.
- Minimum spacing: 2 cycles per command (ARB + ISSUE).
- Read routing adds 0 cycles: `p_rd_valid` is in the same cycle as `rd_data_valid`.
- Tag pointers wrap modulo TAG_DEPTH. The count is one bit wider than the pointers.

## Configuration
- `DDR3_ARB_WR_PRIORITY_EN`:
  - Defined: in ARB, eligible write ports win over eligible read ports. Round-robin applies within the write group, then within the read group, sharing the single `rr_ptr`.
  - Undefined: pure round-robin over all eligible ports, regardless of direction.

## Structure
- Package `ddr3_arb_pkg`:
  - `DDR3_ADDR_W=27`, `DDR3_DATA_W=128`.
  - `CMD_WR=3'b000`, `CMD_RD=3'b001`.
  - FSM state encoding: one-hot IDLE/ARB/ISSUE.
- Sub-module `ddr3_arb_tag_fifo`: synchronous FIFO, width $clog2(PORTS), depth TAG_DEPTH, with full/empty/count outputs.

## Test plan
- Hold `init_calib_complete=0`, `p_req=2'b11` for 10 cycles -> `cmd_en` stays 0. Raise calib -> `cmd_en` 2 cycles later.
- PORTS=2, both ports writing continuously, `cmd_ready=wr_data_rdy=1` -> `p_ack` alternates 01,10,01,10, one ack every 2 cycles, with `wr_data` matching the granted port.
- Port1 reads addr 0x40, port0 reads addr 0x80; IP returns A then B -> `p_rd_valid=10` with A, then `01` with B; `rd_outstanding` goes 1,2,1,0.
- TAG_DEPTH=2 with two unreturned reads, port0 read pending and port1 write pending -> port1 write acked, port0 not acked until one `rd_data_valid` arrives.
- `rd_data_valid` pulsed with no outstanding reads -> no `p_rd_valid`, `tag_err=1` until reset.
- Priority macro defined, both ports requesting with port0 read and port1 write, `rr_ptr=0` -> port1 granted first. Macro undefined -> port0 granted first.
